// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state type and request-classification helpers for the LSU memory port.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic half;
    half = (funct3 == F3_H) || (funct3 == F3_HU);
    return (half && off[0]) || ((funct3 == F3_W) && (off != 2'b00));
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) begin
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Pipeline-side request/response bundle of the LSU memory port; master = MEM stage, slave = LSU.
interface lsu_mem_port_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = XLEN
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [XLEN-1:0]       req_wdata;
  logic                  resp_valid;
  logic [XLEN-1:0]       resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_lane_unit.sv
// Combinational byte/half lane logic: load extract with sign/zero extend, and store merge into an old word.
module lsu_lane_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] ld_word_i,
  input  logic [1:0]      ld_off_i,
  input  logic [2:0]      ld_funct3_i,
  output logic [XLEN-1:0] ld_data_o,
  input  logic [XLEN-1:0] st_old_i,
  input  logic [XLEN-1:0] st_new_i,
  input  logic [1:0]      st_off_i,
  input  logic [1:0]      st_size_i,
  output logic [XLEN-1:0] st_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ld_word_i[{ld_off_i, 3'b000} +: 8];
    ld_half = ld_word_i[{ld_off_i[1], 4'b0000} +: 16];
    // funct3[2] set means the unsigned variant
    case (ld_funct3_i)
      F3_B, F3_BU: ld_data_o = {{(XLEN-8){ld_byte[7] & ~ld_funct3_i[2]}}, ld_byte};
      F3_H, F3_HU: ld_data_o = {{(XLEN-16){ld_half[15] & ~ld_funct3_i[2]}}, ld_half};
      default:     ld_data_o = ld_word_i;
    endcase
  end

  always_comb begin
    st_data_o = st_old_i;
    case (st_size_i)
      2'b00:   st_data_o[{st_off_i, 3'b000} +: 8]     = st_new_i[7:0];
      2'b01:   st_data_o[{st_off_i[1], 4'b0000} +: 16] = st_new_i[15:0];
      default: st_data_o = st_new_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// RV32 load/store initiator onto a word-wide single-port memory; sub-word stores take a 2-cycle read-modify-write.
// Define LSU_MISALIGN_CHECK_EN to flag misaligned halfword/word accesses as errors instead of ignoring low address bits.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  lsu_mem_port_if.slave         bus,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic [XLEN-1:0]       mem_rdata
);

  lsu_state_t            state_q, state_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [XLEN-1:0]       resp_rdata_q, resp_rdata_d;
  logic [ADDR_WIDTH-3:0] cap_waddr_q, cap_waddr_d;
  logic [1:0]            cap_size_q, cap_size_d;
  logic [1:0]            cap_off_q, cap_off_d;
  logic [XLEN-1:0]       cap_wdata_q, cap_wdata_d;
  logic [XLEN-1:0]       cap_rdata_q, cap_rdata_d;

  logic                  req_ready;
  logic                  req_bad;
  logic [XLEN-1:0]       ld_data;
  logic [XLEN-1:0]       st_data;

`ifdef LSU_MISALIGN_CHECK_EN
  assign req_bad = !is_legal(bus.req_we, bus.req_funct3) ||
                   is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
  assign req_bad = !is_legal(bus.req_we, bus.req_funct3);
`endif

  lsu_lane_unit #(.XLEN(XLEN)) u_lane (
    .ld_word_i   (mem_rdata),
    .ld_off_i    (bus.req_addr[1:0]),
    .ld_funct3_i (bus.req_funct3),
    .ld_data_o   (ld_data),
    .st_old_i    (cap_rdata_q),
    .st_new_i    (cap_wdata_q),
    .st_off_i    (cap_off_q),
    .st_size_i   (cap_size_q),
    .st_data_o   (st_data)
  );

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    cap_waddr_d  = cap_waddr_q;
    cap_size_d   = cap_size_q;
    cap_off_d    = cap_off_q;
    cap_wdata_d  = cap_wdata_q;
    cap_rdata_d  = cap_rdata_q;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        mem_addr  = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
        if (bus.req_valid) begin
          resp_valid_d = 1'b1;
          if (req_bad) begin
            resp_err_d = 1'b1;
          end else if (!bus.req_we) begin
            resp_rdata_d = ld_data;
          end else if (bus.req_funct3 == F3_W) begin
            mem_we    = 1'b1;
            mem_wdata = bus.req_wdata;
          end else begin
            // Sub-word store: snapshot the old word now, write the merge next cycle
            resp_valid_d = 1'b0;
            state_d      = RMW;
            cap_waddr_d  = bus.req_addr[ADDR_WIDTH-1:2];
            cap_size_d   = bus.req_funct3[1:0];
            cap_off_d    = bus.req_addr[1:0];
            cap_wdata_d  = bus.req_wdata;
            cap_rdata_d  = mem_rdata;
          end
        end
      end
      RMW: begin
        mem_addr     = {cap_waddr_q, 2'b00};
        mem_we       = 1'b1;
        mem_wdata    = st_data;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset dominates so an in-flight RMW never reaches memory
    if (!rst) begin
      req_ready = 1'b1;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      cap_waddr_q  <= '0;
      cap_size_q   <= '0;
      cap_off_q    <= '0;
      cap_wdata_q  <= '0;
      cap_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      cap_waddr_q  <= cap_waddr_d;
      cap_size_q   <= cap_size_d;
      cap_off_q    <= cap_off_d;
      cap_wdata_q  <= cap_wdata_d;
      cap_rdata_q  <= cap_rdata_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port against a byte-array memory model with expected response cycles.
module tb_lsu_mem_port;

  localparam int XLEN = 32;
  localparam int AW   = 32;
  localparam int NW   = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_port_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) bus ();

  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  logic [31:0] dmem  [NW];
  logic [7:0]  ref_b [NW*4];

  lsu_mem_port #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = dmem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t expq[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops one expectation per resp_valid pulse
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        me = expq.pop_front();
        chk("resp_err", {31'b0, bus.resp_err}, {31'b0, me.err});
        chk("resp_rdata", bus.resp_rdata, me.rdata);
        chk("resp_cycle", cyc, me.cyc);
      end
    end
  end

  // Reference: memory as little-endian bytes; applied at acceptance since ops complete in order
  function automatic void model(input logic we, input logic [2:0] f3, input logic [7:0] a,
                                input logic [31:0] wd, output logic err,
                                output logic [31:0] rd, output int lat);
    logic        legal, mis;
    int          nbytes, base;
    logic [31:0] v;
    legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = (int'(a) % nbytes) != 0;
`else
    mis = 1'b0;
`endif
    base = int'(a) - (int'(a) % nbytes);
    err  = !legal || mis;
    rd   = 32'h0;
    lat  = 1;
    if (err) return;
    if (!we) begin
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v = v | (32'(ref_b[base+i]) << (8*i));
      if (!f3[2] && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
      rd = v;
    end else begin
      for (int i = 0; i < nbytes; i++) ref_b[base+i] = wd[8*i +: 8];
      lat = (nbytes < 4) ? 2 : 1;
    end
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [7:0] a,
                       input logic [31:0] wd, output int waited);
    exp_t        e;
    logic        err;
    logic [31:0] rd;
    int          lat;
    bit          ok;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = {24'b0, a};
    bus.req_wdata  = wd;
    waited = 0;
    ok     = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 for 8 cycles expected acceptance (addr %h)", a);
    end else begin
      model(we, f3, a, wd, err, rd, lat);
      chk("mem_we_on_accept", {31'b0, mem_we}, {31'b0, (we && !err && f3 == 3'd2)});
      chk("mem_addr_on_accept", mem_addr, {24'b0, a & 8'hFC});
      e.err   = err;
      e.rdata = rd;
      e.cyc   = cyc + lat;
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  int          w;
  int          stalls;
  logic [31:0] word, saved;
  bit          ok2;

  initial begin
    for (int i = 0; i < NW; i++) begin
      word = $urandom;
      if (i == 4)  word = 32'h8081_F0FF;
      if (i == 8)  word = 32'h1122_3344;
      if (i == 16) word = 32'h0BAD_F00D;
      dmem[i] <= word;
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = word[8*k +: 8];
    end
    // A SW presented during reset must not reach memory
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h5C;
    bus.req_wdata  = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;

    // Reset in the middle of an SB read-modify-write abandons it
    saved = 32'h0BAD_F00D;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h41;
    bus.req_wdata  = 32'h0000_005A;
    ok2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        ok2 = 1'b1;
        break;
      end
    end
    chk("rmw_rst_accept", {31'b0, ok2}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rst_mem_we", {31'b0, mem_we}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rmw_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rmw_rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rmw_rst_word", dmem[16], saved);
    @(posedge clk);
    #1;

    // Directed loads on 0x8081_F0FF
    issue(1'b0, 3'd0, 8'h11, 32'h0, w); chk("lb_wait", w, 0);
    issue(1'b0, 3'd4, 8'h11, 32'h0, w); chk("lbu_wait", w, 0);
    issue(1'b0, 3'd1, 8'h12, 32'h0, w); chk("lh_wait", w, 0);
    issue(1'b0, 3'd5, 8'h12, 32'h0, w); chk("lhu_wait", w, 0);
    issue(1'b0, 3'd2, 8'h10, 32'h0, w); chk("lw_wait", w, 0);

    // SB RMW: upper bits of wdata must be ignored
    issue(1'b1, 3'd0, 8'h22, 32'hFFFF_FFAB, w);
    @(negedge clk);
    chk("rmw_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rmw_mem_we", {31'b0, mem_we}, 32'd1);
    chk("rmw_mem_addr", mem_addr, 32'h20);
    chk("rmw_mem_wdata", mem_wdata, 32'h11AB_3344);
    @(posedge clk);
    #1;
    chk("sb_word", dmem[8], 32'h11AB_3344);

    // SW then LW with no bubble
    issue(1'b1, 3'd2, 8'h30, 32'hDEAD_BEEF, w); chk("sw_wait", w, 0);
    issue(1'b0, 3'd2, 8'h30, 32'h0, w);         chk("lw_after_sw_wait", w, 0);

    // Illegal funct3 and the LH @0x21 case
    issue(1'b0, 3'd3, 8'h10, 32'h0, w);
    issue(1'b1, 3'd3, 8'h10, 32'h1234_5678, w);
    issue(1'b1, 3'd4, 8'h10, 32'h1234_5678, w);
    issue(1'b0, 3'd7, 8'h10, 32'h0, w);
    issue(1'b0, 3'd1, 8'h21, 32'h0, w);
    issue(1'b1, 3'd1, 8'h21, 32'h0000_7777, w);
    issue(1'b1, 3'd2, 8'h33, 32'h5555_AAAA, w);

    // Eight back-to-back loads
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 3'($urandom_range(0, 5) == 3 ? 2 : $urandom_range(0, 2)),
            8'($urandom_range(0, 63) * 4), 32'h0, w);
      stalls += w;
    end
    chk("b2b_stalls", stalls, 0);

    // Randomised mix with idle gaps
    for (int i = 0; i < 400; i++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            $urandom, w);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    for (int i = 0; i < NW; i++) begin
      word = 32'h0;
      for (int k = 0; k < 4; k++) word = word | (32'(ref_b[4*i+k]) << (8*k));
      chk($sformatf("mem_word_%0d", i), dmem[i], word);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
